// File: rtl/clk_div_bank.sv
// Reconfigurable bank of NUM_CH clock dividers with per-channel high/low/phase/enable and a lock FSM.
// Optional macro CLKDIV_PHASE_PRESET_EN adds per-channel phase-preset delay counters.
module clk_div_bank #(
    parameter int NUM_CH      = 7,
    parameter int CW          = 8,
    parameter int PW          = 8,
    parameter int DEF_HI      = 2,
    parameter int DEF_LO      = 2,
    parameter int LOCK_CYCLES = 16,
    localparam int CHW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_wr,
    input  logic [CHW-1:0]    cfg_chan,
    input  logic [CW-1:0]     cfg_hi,
    input  logic [CW-1:0]     cfg_lo,
    input  logic [PW-1:0]     cfg_prst,
    input  logic              cfg_en,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] outclk,
    output logic [NUM_CH-1:0] period_tick,
    output logic              locked
);

    localparam int SW = $clog2(LOCK_CYCLES + 1);
    localparam logic [CHW:0] NUM_CH_W = (CHW + 1)'(NUM_CH);

    typedef enum logic [0:0] {SETTLE, LOCKED} lock_state_t;

    logic        wr_valid;
    logic        start_q, start_d;
    logic        err_q, err_d;
    lock_state_t state_q;
    logic [SW-1:0] settle_q;
    logic        locked_q;

    always_comb begin
        wr_valid = cfg_wr && ({1'b0, cfg_chan} < NUM_CH_W)
                   && (cfg_hi != '0) && (cfg_lo != '0);
        // start_q marks that the coming edge is cycle 0 for every channel
        start_d = wr_valid;
        err_d   = cfg_wr && !wr_valid;
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            start_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            start_q <= start_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q  <= SETTLE;
            settle_q <= '0;
            locked_q <= 1'b0;
        end else if (wr_valid) begin
            state_q  <= SETTLE;
            settle_q <= '0;
            locked_q <= 1'b0;
        end else begin
            case (state_q)
                SETTLE: begin
                    if (settle_q == SW'(LOCK_CYCLES)) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                    end else begin
                        settle_q <= settle_q + SW'(1);
                    end
                end
                LOCKED: locked_q <= 1'b1;
                default: begin
                    state_q  <= SETTLE;
                    settle_q <= '0;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_err = err_q;
    assign locked  = locked_q;

`ifndef CLKDIV_PHASE_PRESET_EN
    logic unused_prst;
    assign unused_prst = ^cfg_prst;
`endif

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic          sel;
            logic [CW-1:0] hi_q, hi_d, lo_q, lo_d;
            logic          en_q, en_d;
            logic [CW:0]   cnt_q, cnt_d, cnt_e, period;
            logic          out_q, out_d, tick_q, tick_d;
            logic          in_pre;
`ifdef CLKDIV_PHASE_PRESET_EN
            logic [PW-1:0] prst_q, prst_d, pre_q, pre_d, pre_e;
`endif

            always_comb begin
                sel  = wr_valid && (cfg_chan == CHW'(gi));
                hi_d = sel ? cfg_hi : hi_q;
                lo_d = sel ? cfg_lo : lo_q;
                en_d = sel ? cfg_en : en_q;
`ifdef CLKDIV_PHASE_PRESET_EN
                prst_d = sel ? cfg_prst : prst_q;
                pre_e  = start_q ? prst_q : pre_q;
                in_pre = (pre_e != '0);
                pre_d  = '0;
`else
                in_pre = 1'b0;
`endif
                period = {1'b0, hi_q} + {1'b0, lo_q};
                cnt_e  = start_q ? '0 : cnt_q;
                out_d  = 1'b0;
                tick_d = 1'b0;
                cnt_d  = '0;
                if (en_q) begin
                    if (in_pre) begin
`ifdef CLKDIV_PHASE_PRESET_EN
                        pre_d = pre_e - PW'(1);
`endif
                    end else begin
                        out_d  = (cnt_e < {1'b0, hi_q});
                        tick_d = (cnt_e == '0);
                        cnt_d  = ((cnt_e + (CW + 1)'(1)) == period) ? '0
                                                                   : cnt_e + (CW + 1)'(1);
                    end
                end
            end

            always_ff @(posedge refclk or posedge rst) begin
                if (rst) begin
                    hi_q   <= CW'(DEF_HI);
                    lo_q   <= CW'(DEF_LO);
                    en_q   <= 1'b1;
                    cnt_q  <= '0;
                    out_q  <= 1'b0;
                    tick_q <= 1'b0;
`ifdef CLKDIV_PHASE_PRESET_EN
                    prst_q <= '0;
                    pre_q  <= '0;
`endif
                end else begin
                    hi_q   <= hi_d;
                    lo_q   <= lo_d;
                    en_q   <= en_d;
                    cnt_q  <= cnt_d;
                    out_q  <= out_d;
                    tick_q <= tick_d;
`ifdef CLKDIV_PHASE_PRESET_EN
                    prst_q <= prst_d;
                    pre_q  <= pre_d;
`endif
                end
            end

            assign outclk[gi]      = out_q;
            assign period_tick[gi] = tick_q;
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_bank.sv
// Scoreboard bench for clk_div_bank: stimulus pushes per-cycle expectations, a negedge monitor checks them.
module tb_clk_div_bank;
    localparam int N     = 5;
    localparam int LOCKC = 16;
`ifdef CLKDIV_PHASE_PRESET_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    logic         refclk = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_wr = 1'b0;
    logic [2:0]   cfg_chan = '0;
    logic [7:0]   cfg_hi = '0, cfg_lo = '0, cfg_prst = '0;
    logic         cfg_en = 1'b0;
    logic         cfg_err;
    logic [N-1:0] outclk, period_tick;
    logic         locked;

    clk_div_bank #(.NUM_CH(N), .CW(8), .PW(8), .DEF_HI(2), .DEF_LO(2), .LOCK_CYCLES(LOCKC)) dut (
        .refclk(refclk), .rst(rst), .cfg_wr(cfg_wr), .cfg_chan(cfg_chan),
        .cfg_hi(cfg_hi), .cfg_lo(cfg_lo), .cfg_prst(cfg_prst), .cfg_en(cfg_en),
        .cfg_err(cfg_err), .outclk(outclk), .period_tick(period_tick), .locked(locked)
    );

    always #5 refclk = ~refclk;

    typedef struct packed {
        logic [N-1:0] clk;
        logic [N-1:0] tick;
        logic         lock;
        logic         err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_hi[N], m_lo[N], m_pr[N];
    bit   m_en[N];
    int   m_t;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge refclk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("outclk", int'(outclk), int'(mon_e.clk));
            chk("period_tick", int'(period_tick), int'(mon_e.tick));
            chk("locked", int'(locked), int'(mon_e.lock));
            chk("cfg_err", int'(cfg_err), int'(mon_e.err));
        end
    end

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_hi[i] = 2; m_lo[i] = 2; m_pr[i] = 0; m_en[i] = 1'b1;
        end
        m_t = 0;
    endtask

    // One refclk edge; expected outputs follow from absolute time since the last resync.
    task automatic cycle(input bit wr, input int ch, input int hi, input int lo,
                         input int pr, input bit en);
        exp_t e;
        bit   valid;
        int   p, m;
        cfg_wr = wr; cfg_chan = 3'(ch); cfg_hi = 8'(hi); cfg_lo = 8'(lo);
        cfg_prst = 8'(pr); cfg_en = en;
        @(posedge refclk);
        e = '0;
        for (int i = 0; i < N; i++) begin
            p = PRE ? m_pr[i] : 0;
            if (m_en[i] && m_t >= p) begin
                m = (m_t - p) % (m_hi[i] + m_lo[i]);
                e.clk[i]  = (m < m_hi[i]);
                e.tick[i] = (m == 0);
            end
        end
        valid  = wr && ch < N && hi != 0 && lo != 0;
        e.lock = !valid && m_t >= LOCKC;
        e.err  = wr && !valid;
        if (valid) begin
            m_hi[ch] = hi; m_lo[ch] = lo; m_pr[ch] = pr; m_en[ch] = en;
            m_t = 0;
        end else begin
            m_t++;
        end
        #1 exp_q.push_back(e);
        cfg_wr = 1'b0;
        $display("cycle t=%0d wr=%0b ch=%0d hi=%0d lo=%0d pr=%0d en=%0b -> exp clk=%b tick=%b lock=%0b err=%0b",
                 m_t, wr, ch, hi, lo, pr, en, e.clk, e.tick, e.lock, e.err);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 0, 0, 0, 0, 1'b0);
    endtask

    // Assert rst between edges, confirm the asynchronous clear, optionally collide with a write.
    task automatic do_reset(input bit with_wr);
        @(negedge refclk);
        #1 rst = 1'b1;
        #1;
        chk("rst_outclk", int'(outclk), 0);
        chk("rst_tick", int'(period_tick), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_err", int'(cfg_err), 0);
        if (with_wr) begin
            cfg_wr = 1'b1; cfg_chan = 3'd1; cfg_hi = 8'd5; cfg_lo = 8'd5; cfg_en = 1'b1;
        end
        @(posedge refclk);
        @(negedge refclk);
        #1 rst = 1'b0;
        cfg_wr = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        do_reset(1'b0);
        idle(20);                              // defaults: 1,1,0,0 and lock at 16
        cycle(1'b1, 1, 3, 1, 2, 1'b1);
        idle(20);
        cycle(1'b1, 5, 2, 2, 0, 1'b1);         // channel out of range
        idle(3);
        cycle(1'b1, 0, 0, 2, 0, 1'b1);         // hi = 0
        idle(3);
        cycle(1'b1, 3, 2, 0, 0, 1'b1);         // lo = 0
        idle(3);
        cycle(1'b1, 2, 2, 2, 0, 1'b0);         // disable ch2
        idle(8);
        cycle(1'b1, 2, 2, 2, 0, 1'b1);
        idle(20);
        cycle(1'b1, 0, 1, 1, 0, 1'b1);
        idle(5);
        cycle(1'b1, 3, 2, 3, 1, 1'b1);         // second write at settle cycle 5
        idle(10);
        cycle(1'b1, 4, 4, 1, 0, 1'b1);         // third write at settle cycle 10
        idle(24);                              // reaches 7 cycles into LOCKED
        do_reset(1'b1);
        idle(20);
        cycle(1'b1, 0, 3, 2, 1, 1'b1);         // back-to-back valid writes
        cycle(1'b1, 4, 1, 3, 0, 1'b1);
        idle(20);
        cycle(1'b1, 1, 2, 2, 3, 1'b1);         // phase preset, honoured only with the macro
        idle(12);
        cycle(1'b1, 1, 255, 1, 0, 1'b1);       // max high count
        idle(6);
        repeat (3) @(negedge refclk);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
